// File: rtl/branch_stack_pkg.sv
// ---------------------------------------------------------------------------
// branch_stack_pkg
//   Shared types for the branch checkpoint manager and its consumers.
//   Provides the branch-resolution task encoding, the branch mask type,
//   the fetch address type and the per-slot stack entry record.
//   `BRANCH_CNT sets the number of in-flight branches (width of BR_MASK).
// ---------------------------------------------------------------------------
`ifndef BRANCH_CNT
`define BRANCH_CNT 4
`endif

package branch_stack_pkg;

  localparam int BR_CHKPT_W = 64;
  localparam int ADDR_W     = 32;

  typedef logic [ADDR_W-1:0]      ADDR;
  typedef logic [`BRANCH_CNT-1:0] BR_MASK;

  typedef enum logic [1:0] {
    NOTHING = 2'd0,
    CLEAR   = 2'd1,
    SQUASH  = 2'd2
  } BR_TASK;

  // One in-flight branch: older_mask holds the IDs of branches dispatched
  // before this one, so a squash of any of them also kills this slot.
  typedef struct packed {
    logic                  valid;
    BR_MASK                older_mask;
    logic [BR_CHKPT_W-1:0] chkpt;
  } BR_STACK_ENTRY;

endpackage

// File: rtl/branch_stack_psel.sv
// ---------------------------------------------------------------------------
// psel_lowest
//   One-hot priority selector: grants the lowest-index set bit of req.
//   Ports:
//     req  in  WIDTH  request vector (here: free slots)
//     gnt  out WIDTH  one-hot grant, all zero when no request
// ---------------------------------------------------------------------------
module psel_lowest #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt
);

  // Walk upward and keep only the first request seen.
  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_stack.sv
// ---------------------------------------------------------------------------
// branch_stack
//   Branch checkpoint manager. Hands out one-hot branch IDs at dispatch,
//   keeps one checkpoint per in-flight branch, and turns branch-FU
//   resolutions into the registered rem_br_task/rem_b_id broadcast. On a
//   squash it returns the squashing branch's checkpoint and the redirect PC.
//   Ports:
//     clock, reset          clock, asynchronous active-high reset
//     alloc_en/alloc_chkpt  dispatch allocation request and its checkpoint
//     alloc_b_id            ID that an allocation this cycle would receive
//     cur_b_mask, full      outstanding-branch vector, no-free-slot flag
//     br_task/br_b_id/br_target  resolution from the branch FU
//     rem_br_task/rem_b_id  registered resolution broadcast
//     restore_valid/restore_chkpt/redirect_pc  squash recovery outputs
//   Optional: define BRANCH_STACK_STATS_EN to add stat_clear_cnt and
//   stat_squash_cnt, saturating counts of accepted CLEAR/SQUASH resolutions.
// ---------------------------------------------------------------------------
module branch_stack
  import branch_stack_pkg::*;
#(
  parameter int DEPTH   = `BRANCH_CNT,
  parameter int CHKPT_W = BR_CHKPT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               alloc_en,
  input  logic [CHKPT_W-1:0] alloc_chkpt,
  output logic [DEPTH-1:0]   alloc_b_id,
  output logic [DEPTH-1:0]   cur_b_mask,
  output logic               full,
  input  BR_TASK             br_task,
  input  logic [DEPTH-1:0]   br_b_id,
  input  ADDR                br_target,
  output BR_TASK             rem_br_task,
  output logic [DEPTH-1:0]   rem_b_id,
  output logic               restore_valid,
  output logic [CHKPT_W-1:0] restore_chkpt,
  output ADDR                redirect_pc
`ifdef BRANCH_STACK_STATS_EN
  ,
  output logic [31:0]        stat_clear_cnt,
  output logic [31:0]        stat_squash_cnt
`endif
);

  BR_STACK_ENTRY      entries [DEPTH];
  logic [DEPTH-1:0]   valid_vec;
  logic [DEPTH-1:0]   free_vec;
  logic [DEPTH-1:0]   kill_vec;
  logic [DEPTH-1:0]   cleared_vec;
  logic [CHKPT_W-1:0] sel_chkpt;
  logic               br_hit;
  logic               accept_clear;
  logic               accept_squash;
  logic               alloc_fire;

  // Flatten slot state into vectors and pre-compute, per slot, whether a
  // squash of br_b_id would kill it (the slot itself or anything younger).
  always_comb begin
    valid_vec = '0;
    kill_vec  = '0;
    sel_chkpt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries[i].valid;
      kill_vec[i]  = br_b_id[i] | (|(entries[i].older_mask & br_b_id));
      sel_chkpt    = sel_chkpt | (entries[i].chkpt & {CHKPT_W{br_b_id[i]}});
    end
  end

  assign free_vec   = ~valid_vec;
  assign cur_b_mask = valid_vec;
  assign full       = &valid_vec;

  psel_lowest #(.WIDTH(DEPTH)) u_psel (
    .req (free_vec),
    .gnt (alloc_b_id)
  );

  // A resolution is honoured only for a single valid branch; anything else
  // (bad one-hot, stale ID, unknown task code) is dropped on the floor.
  always_comb begin
    br_hit        = $onehot(br_b_id) && (|(br_b_id & valid_vec));
    accept_clear  = br_hit && (br_task == CLEAR);
    accept_squash = br_hit && (br_task == SQUASH);
    cleared_vec   = accept_clear ? br_b_id : '0;
    alloc_fire    = alloc_en && !full && !accept_squash;
  end

  // Slot state. The grant comes from the pre-resolution valid vector, so a
  // slot freed this cycle cannot be handed out until the next cycle. A new
  // branch records every surviving valid branch as older than itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (accept_squash && kill_vec[i]) begin
          entries[i].valid <= 1'b0;
        end else if (accept_clear && br_b_id[i]) begin
          entries[i].valid <= 1'b0;
        end else if (alloc_fire && alloc_b_id[i]) begin
          entries[i].valid      <= 1'b1;
          entries[i].older_mask <= valid_vec & ~cleared_vec;
          entries[i].chkpt      <= alloc_chkpt;
        end
        if (accept_clear && !(alloc_fire && alloc_b_id[i])) begin
          entries[i].older_mask <= entries[i].older_mask & ~br_b_id;
        end
      end
    end
  end

  // Broadcast registers: one-cycle latency, falling back to NOTHING when no
  // resolution was accepted. Restore data holds until the next squash.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_br_task   <= NOTHING;
      rem_b_id      <= '0;
      restore_valid <= 1'b0;
      restore_chkpt <= '0;
      redirect_pc   <= '0;
    end else begin
      rem_br_task   <= accept_clear ? CLEAR : (accept_squash ? SQUASH : NOTHING);
      rem_b_id      <= (accept_clear || accept_squash) ? br_b_id : '0;
      restore_valid <= accept_squash;
      if (accept_squash) begin
        restore_chkpt <= sel_chkpt;
        redirect_pc   <= br_target;
      end
    end
  end

`ifdef BRANCH_STACK_STATS_EN
  // Saturating counts of accepted resolutions for performance analysis.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_clear_cnt  <= '0;
      stat_squash_cnt <= '0;
    end else begin
      if (accept_clear && (stat_clear_cnt != 32'hFFFF_FFFF)) begin
        stat_clear_cnt <= stat_clear_cnt + 32'd1;
      end
      if (accept_squash && (stat_squash_cnt != 32'hFFFF_FFFF)) begin
        stat_squash_cnt <= stat_squash_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_stack.sv
// ---------------------------------------------------------------------------
// tb_branch_stack
//   Directed self-checking bench for branch_stack. Each step drives one
//   cycle of dispatch/resolution input and queues the broadcast expected on
//   the following cycle; after the edge the queue head is compared against
//   rem_br_task/rem_b_id/restore_*. Slot state is checked through
//   cur_b_mask/full/alloc_b_id and through which checkpoints squashes return.
// ---------------------------------------------------------------------------
module tb_branch_stack;
  import branch_stack_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 64;

  logic             clock = 1'b0;
  logic             reset;
  logic             alloc_en;
  logic [CW-1:0]    alloc_chkpt;
  logic [DEPTH-1:0] alloc_b_id;
  logic [DEPTH-1:0] cur_b_mask;
  logic             full;
  BR_TASK           br_task;
  logic [DEPTH-1:0] br_b_id;
  ADDR              br_target;
  BR_TASK           rem_br_task;
  logic [DEPTH-1:0] rem_b_id;
  logic             restore_valid;
  logic [CW-1:0]    restore_chkpt;
  ADDR              redirect_pc;
`ifdef BRANCH_STACK_STATS_EN
  logic [31:0]      stat_clear_cnt;
  logic [31:0]      stat_squash_cnt;
`endif

  branch_stack #(.DEPTH(DEPTH), .CHKPT_W(CW)) dut (
    .clock         (clock),
    .reset         (reset),
    .alloc_en      (alloc_en),
    .alloc_chkpt   (alloc_chkpt),
    .alloc_b_id    (alloc_b_id),
    .cur_b_mask    (cur_b_mask),
    .full          (full),
    .br_task       (br_task),
    .br_b_id       (br_b_id),
    .br_target     (br_target),
    .rem_br_task   (rem_br_task),
    .rem_b_id      (rem_b_id),
    .restore_valid (restore_valid),
    .restore_chkpt (restore_chkpt),
    .redirect_pc   (redirect_pc)
`ifdef BRANCH_STACK_STATS_EN
    ,
    .stat_clear_cnt  (stat_clear_cnt),
    .stat_squash_cnt (stat_squash_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    BR_TASK      t;
    logic [3:0]  id;
    logic        rv;
    logic [63:0] ck;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setIdle();
    alloc_en    = 1'b0;
    alloc_chkpt = '0;
    br_task     = NOTHING;
    br_b_id     = '0;
    br_target   = '0;
  endtask

  // Pop the broadcast expected for the cycle that just completed.
  task automatic checkBroadcast(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty observed=%0d expected=1", tag, sb.size());
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_task"}, 64'(rem_br_task), 64'(e.t));
      checkOutput({tag, "_id"}, 64'(rem_b_id), 64'(e.id));
      checkOutput({tag, "_rv"}, 64'(restore_valid), 64'(e.rv));
      if (e.rv) begin
        checkOutput({tag, "_chkpt"}, restore_chkpt, e.ck);
        checkOutput({tag, "_pc"}, 64'(redirect_pc), 64'(e.pc));
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic ae, input logic [63:0] ack,
                               input BR_TASK t, input logic [3:0] id, input logic [31:0] tgt,
                               input BR_TASK et, input logic [3:0] eid,
                               input logic [63:0] eck, input logic [31:0] epc);
    alloc_en    = ae;
    alloc_chkpt = ack;
    br_task     = t;
    br_b_id     = id;
    br_target   = tgt;
    sb.push_back('{et, eid, (et == SQUASH), eck, epc});
    tick();
    setIdle();
    checkBroadcast(tag);
  endtask

  task automatic doAlloc(input string tag, input logic [63:0] ck);
    applyStimulus(tag, 1'b1, ck, NOTHING, 4'b0000, 32'h0, NOTHING, 4'b0000, 64'h0, 32'h0);
  endtask

  task automatic checkState(input string tag, input logic [3:0] m, input logic f, input logic [3:0] g);
    checkOutput({tag, "_mask"}, 64'(cur_b_mask), 64'(m));
    checkOutput({tag, "_full"}, 64'(full), 64'(f));
    checkOutput({tag, "_grant"}, 64'(alloc_b_id), 64'(g));
  endtask

  // Reset asserted between edges must clear the slots without waiting.
  task automatic doReset(input string tag);
    reset = 1'b1;
    #2;
    checkState({tag, "_async"}, 4'b0000, 1'b0, 4'b0001);
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    $display("[TB] branch_stack directed test start");
    setIdle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkState("rst", 4'b0000, 1'b0, 4'b0001);
    checkOutput("rst_task", 64'(rem_br_task), 64'(NOTHING));
    checkOutput("rst_id", 64'(rem_b_id), 64'h0);
    checkOutput("rst_rv", 64'(restore_valid), 64'h0);
    checkOutput("rst_chkpt", restore_chkpt, 64'h0);
    checkOutput("rst_pc", 64'(redirect_pc), 64'h0);

    // Fill the stack in order, then a fifth allocation is ignored
    for (int i = 0; i < 4; i++) begin
      checkOutput("t1_grant", 64'(alloc_b_id), 64'(1) << i);
      doAlloc("t1_alloc", 64'hA0 + 64'(i));
    end
    checkState("t1_full", 4'b1111, 1'b1, 4'b0000);
    doAlloc("t1_over", 64'hDEAD);
    checkState("t1_over", 4'b1111, 1'b1, 4'b0000);

    // CLEAR slot 1 from full; the freed slot is reused and the survivors
    // no longer count it as older, so squashing it kills only itself
    applyStimulus("t2_clr", 1'b0, 64'h0, CLEAR, 4'b0010, 32'h0, CLEAR, 4'b0010, 64'h0, 32'h0);
    checkState("t2_clr", 4'b1101, 1'b0, 4'b0010);
    doAlloc("t2_realloc", 64'hB1);
    checkState("t2_realloc", 4'b1111, 1'b1, 4'b0000);
    applyStimulus("t2_sq1", 1'b0, 64'h0, SQUASH, 4'b0010, 32'h0BAD, SQUASH, 4'b0010, 64'hB1, 32'h0BAD);
    checkState("t2_sq1", 4'b1101, 1'b0, 4'b0010);
    applyStimulus("t2_sq3", 1'b0, 64'h0, SQUASH, 4'b1000, 32'h0C00, SQUASH, 4'b1000, 64'hA3, 32'h0C00);
    checkState("t2_sq3", 4'b0101, 1'b0, 4'b0010);

    // A, B, C then squash B: C goes with it, A survives
    doReset("t3_rst");
    doAlloc("t3_a", 64'hC0);
    doAlloc("t3_b", 64'hC1);
    doAlloc("t3_c", 64'hC2);
    applyStimulus("t3_sq", 1'b0, 64'h0, SQUASH, 4'b0010, 32'h1040, SQUASH, 4'b0010, 64'hC1, 32'h1040);
    checkState("t3_sq", 4'b0001, 1'b0, 4'b0010);
    applyStimulus("t3_idle", 1'b0, 64'h0, NOTHING, 4'b0000, 32'h0, NOTHING, 4'b0000, 64'h0, 32'h0);

    // Allocation alongside a squash is dropped
    applyStimulus("t4_sqa", 1'b1, 64'hEE, SQUASH, 4'b0001, 32'h2000, SQUASH, 4'b0001, 64'hC0, 32'h2000);
    checkState("t4_sqa", 4'b0000, 1'b0, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      doAlloc("t4_fill", 64'hD0 + 64'(i));
    end
    checkState("t4_fill", 4'b1111, 1'b1, 4'b0000);
    // Allocation alongside a CLEAR while full gets nothing this cycle
    applyStimulus("t4_clrf", 1'b1, 64'hEF, CLEAR, 4'b0001, 32'h0, CLEAR, 4'b0001, 64'h0, 32'h0);
    checkState("t4_clrf", 4'b1110, 1'b0, 4'b0001);
    // Not full: allocation takes slot 0, not the slot cleared this cycle
    applyStimulus("t4_clra", 1'b1, 64'hE0, CLEAR, 4'b0010, 32'h0, CLEAR, 4'b0010, 64'h0, 32'h0);
    checkState("t4_clra", 4'b1101, 1'b0, 4'b0010);
    applyStimulus("t4_sq0", 1'b0, 64'h0, SQUASH, 4'b0001, 32'h3000, SQUASH, 4'b0001, 64'hE0, 32'h3000);
    checkState("t4_sq0", 4'b1100, 1'b0, 4'b0001);
    applyStimulus("t4_sq2", 1'b0, 64'h0, SQUASH, 4'b0100, 32'h3100, SQUASH, 4'b0100, 64'hD2, 32'h3100);
    checkState("t4_sq2", 4'b0000, 1'b0, 4'b0001);

    // Bad resolutions are ignored and broadcast NOTHING
    doAlloc("t5_alloc", 64'hF0);
    applyStimulus("t5_sqinv", 1'b0, 64'h0, SQUASH, 4'b0100, 32'h4000, NOTHING, 4'b0000, 64'h0, 32'h0);
    checkState("t5_sqinv", 4'b0001, 1'b0, 4'b0010);
    applyStimulus("t5_clr2h", 1'b0, 64'h0, CLEAR, 4'b0011, 32'h0, NOTHING, 4'b0000, 64'h0, 32'h0);
    applyStimulus("t5_sq2h", 1'b0, 64'h0, SQUASH, 4'b0011, 32'h4100, NOTHING, 4'b0000, 64'h0, 32'h0);
    applyStimulus("t5_clr0", 1'b0, 64'h0, CLEAR, 4'b0000, 32'h0, NOTHING, 4'b0000, 64'h0, 32'h0);
    checkState("t5_bad", 4'b0001, 1'b0, 4'b0010);
    applyStimulus("t5_clrok", 1'b0, 64'h0, CLEAR, 4'b0001, 32'h0, CLEAR, 4'b0001, 64'h0, 32'h0);
    checkState("t5_clrok", 4'b0000, 1'b0, 4'b0001);

`ifdef BRANCH_STACK_STATS_EN
    // Counters track accepted resolutions and clear on reset
    doReset("t6_rst");
    checkOutput("t6_clr0", 64'(stat_clear_cnt), 64'h0);
    checkOutput("t6_sq0", 64'(stat_squash_cnt), 64'h0);
    for (int i = 0; i < 4; i++) begin
      doAlloc("t6_fill", 64'h60 + 64'(i));
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus("t6_clr", 1'b0, 64'h0, CLEAR, 4'(1 << i), 32'h0, CLEAR, 4'(1 << i), 64'h0, 32'h0);
    end
    applyStimulus("t6_sqa", 1'b0, 64'h0, SQUASH, 4'b1000, 32'h5000, SQUASH, 4'b1000, 64'h63, 32'h5000);
    applyStimulus("t6_bad", 1'b0, 64'h0, SQUASH, 4'b1000, 32'h5100, NOTHING, 4'b0000, 64'h0, 32'h0);
    doAlloc("t6_alloc", 64'h70);
    applyStimulus("t6_sqb", 1'b0, 64'h0, SQUASH, 4'b0001, 32'h5200, SQUASH, 4'b0001, 64'h70, 32'h5200);
    checkOutput("t6_clrcnt", 64'(stat_clear_cnt), 64'd3);
    checkOutput("t6_sqcnt", 64'(stat_squash_cnt), 64'd2);
    doAlloc("t6_a0", 64'h80);
    doAlloc("t6_a1", 64'h81);
    checkState("t6_two", 4'b0011, 1'b0, 4'b0100);
    reset = 1'b1;
    #2;
    checkState("t6_mid", 4'b0000, 1'b0, 4'b0001);
    checkOutput("t6_clrrst", 64'(stat_clear_cnt), 64'h0);
    checkOutput("t6_sqrst", 64'(stat_squash_cnt), 64'h0);
    tick();
    reset = 1'b0;
    sb.delete();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
